// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer that steps a combinational microcode ROM with conditional branches
// Ports: clk rising-edge clock; rst_n asynchronous active-low reset;
//   start runs the program from address 0; abort stops a running program;
//   cond holds the branch flags; rom_data is the microword read at rom_addr (always equal to upc);
//   ctrl carries the datapath controls (the word's sig field while RUN, 0 otherwise);
//   busy is high in RUN; done pulses in FIN; err pulses for one cycle after a fault.
// Define USEQ_CTRL_WDOG_EN to add a watchdog that faults after WDOG_CYCLES RUN cycles.
module useq_ctrl #(
  parameter int ROM_DEPTH   = 18,
  parameter int DONE_ADDR   = 17,
  parameter int WDOG_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  cond,
  input  logic [22:0] rom_data,
  output logic [4:0]  rom_addr,
  output logic [14:0] ctrl,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [5:0] DEPTH = 6'(ROM_DEPTH);
  localparam logic [4:0] DONE  = 5'(DONE_ADDR);
  state_t state, state_nx;
  logic [4:0] upc, upc_nx, tgt, nxt;
  logic [2:0] op;
  logic take, err_q, err_nx, wdog_hit;
  assign op       = rom_data[22:20];
  assign nxt      = rom_data[19:15];
  assign rom_addr = upc;
  assign ctrl     = state == RUN ? rom_data[14:0] : '0;
  assign busy     = state == RUN;
  assign done     = state == FIN;
  assign err      = err_q;
`ifdef USEQ_CTRL_WDOG_EN
  localparam logic [7:0] WLIM = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog;
  // Held at zero outside RUN, so it restarts on every entry to RUN.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog <= '0;
    else wdog <= state == RUN ? wdog + 8'd1 : '0;
  assign wdog_hit = wdog == WLIM;
`else
  assign wdog_hit = WDOG_CYCLES < 0;
`endif
  always_comb begin
    take = op == 3'd0 || (op == 3'd1 && cond[0]) || (op == 3'd2 && cond[1])
        || (op == 3'd3 && cond[2]) || (op == 3'd4 && cond[3]);
    tgt = take ? nxt : upc + 5'd1;
    state_nx = state;
    upc_nx = upc;
    err_nx = 1'b0;
    case (state)
      IDLE: if (start && !abort) begin
        state_nx = RUN;
        upc_nx = '0;
      end
      RUN: if (abort) state_nx = IDLE;
      else if (upc == DONE) state_nx = FIN;
      else if ({1'b0, tgt} >= DEPTH || wdog_hit) begin
        state_nx = IDLE;
        upc_nx = '0;
        err_nx = 1'b1;
      end
      else upc_nx = tgt;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      upc <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      upc <= upc_nx;
      err_q <= err_nx;
    end
endmodule
